// File: rtl/epl_frame_detect.sv
// epl_frame_detect
//   Passive RMII receive-side POWERLINK frame classifier. Finds preamble/SFD,
//   assembles bytes from LSB-first dibits, checks the EtherType, extracts the
//   message type and node IDs, and pulses soc_det one clk after the strobe
//   that samples the last dibit of an SoC message-type byte. It never drives
//   the medium.
//
// Ports
//   clk, rst                 50 MHz clock, synchronous active-high reset
//   fast_eth                 1 = dibit every clk, 0 = dibit every SLOW_DIV clk
//   rm_crs_dv, rm_rx_data    RMII receive pins
//   soc_det, hdr_vld         1-clk pulses: SoC seen / header bytes 14..16 valid
//   is_epl                   EtherType matched, held until next SFD
//   msg_type, dst_node,
//   src_node                 header fields (bytes 14, 15, 16), held
//   frame_done, frame_err    1-clk pulses at end of carrier; error on runt/misalign
//   frame_len                bytes received after SFD (saturating), held
module epl_frame_detect #(
    parameter int          L         = 11,
    parameter logic [15:0] ETHERTYPE = 16'h88AB,
    parameter int          SLOW_DIV  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fast_eth,
    input  logic         rm_crs_dv,
    input  logic [1:0]   rm_rx_data,
    output logic         soc_det,
    output logic         hdr_vld,
    output logic         is_epl,
    output logic [6:0]   msg_type,
    output logic [7:0]   dst_node,
    output logic [7:0]   src_node,
    output logic         frame_done,
    output logic [L-1:0] frame_len,
    output logic         frame_err
);

    localparam int DW = $clog2(SLOW_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_END} state_t;

    // ---------------- sample strobe ----------------
    // At 10 Mbit the divider is realigned to the carrier rising edge so the
    // strobe lands mid-dibit (count SLOW_DIV/2) for the whole frame.
    logic          crs_q;
    logic [DW-1:0] div_q, div_d, div_cnt;
    logic          strobe;

    always_comb begin
        div_cnt = (rm_crs_dv && !crs_q) ? '0 : div_q;
        div_d   = (div_cnt == DW'(SLOW_DIV - 1)) ? '0 : div_cnt + 1'b1;
        strobe  = fast_eth || (div_cnt == DW'(SLOW_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crs_q <= 1'b0;
            div_q <= '0;
        end else begin
            crs_q <= rm_crs_dv;
            div_q <= div_d;
        end
    end

    // ---------------- frame FSM ----------------
    state_t       state_q;
    logic [7:0]   sh_q;        // byte being assembled
    logic [7:0]   byte_d;      // byte including the current dibit
    logic [1:0]   ph_q;        // dibit phase within byte
    logic [L-1:0] cnt_q;       // completed bytes after SFD
    logic [7:0]   eth_hi_q;    // EtherType MSB (byte 12)
    logic         soc_q, hdr_q, epl_q, done_q, err_q;
    logic [6:0]   msg_q;
    logic [7:0]   dst_q, src_q;
    logic [L-1:0] len_q;

    assign byte_d = {rm_rx_data, sh_q[7:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            ph_q     <= '0;
            cnt_q    <= '0;
            eth_hi_q <= '0;
            soc_q    <= 1'b0;
            hdr_q    <= 1'b0;
            epl_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            msg_q    <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            len_q    <= '0;
        end else begin
            // pulses last exactly one clk
            soc_q  <= 1'b0;
            hdr_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == S_END) begin
                state_q <= S_IDLE;
            end else if (strobe) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rm_crs_dv && rm_rx_data == 2'b01) state_q <= S_PRE;
                    end
                    S_PRE: begin
                        if (!rm_crs_dv || rm_rx_data == 2'b10) begin
                            state_q <= S_IDLE;
                        end else if (rm_rx_data == 2'b11) begin
                            // SFD tail: start of a new frame
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            ph_q    <= '0;
                            epl_q   <= 1'b0;
                            msg_q   <= '0;
                            dst_q   <= '0;
                            src_q   <= '0;
                        end
                        // 2'b01 preamble and 2'b00 false carrier stay in PRE
                    end
                    S_DATA: begin
                        if (!rm_crs_dv) begin
                            state_q <= S_END;
                            done_q  <= 1'b1;
                            len_q   <= cnt_q;
                            err_q   <= (cnt_q < L'(17)) || (ph_q != 2'd0);
                        end else begin
                            sh_q <= byte_d;
                            ph_q <= ph_q + 2'd1;
                            if (ph_q == 2'd3) begin
                                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                                if (cnt_q == L'(12)) eth_hi_q <= byte_d;
                                if (cnt_q == L'(13)) epl_q <= ({eth_hi_q, byte_d} == ETHERTYPE);
                                if (cnt_q == L'(14)) begin
                                    msg_q <= byte_d[6:0];
                                    soc_q <= epl_q && (byte_d[6:0] == 7'h01);
                                end
                                if (cnt_q == L'(15)) dst_q <= byte_d;
                                if (cnt_q == L'(16)) begin
                                    src_q <= byte_d;
                                    hdr_q <= epl_q;
                                end
                            end
                        end
                    end
                    S_END: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign soc_det    = soc_q;
    assign hdr_vld    = hdr_q;
    assign is_epl     = epl_q;
    assign msg_type   = msg_q;
    assign dst_node   = dst_q;
    assign src_node   = src_q;
    assign frame_done = done_q;
    assign frame_len  = len_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_epl_frame_detect.sv
// Directed bench for epl_frame_detect: drives whole RMII frames dibit by
// dibit and checks event counts, latencies and held fields against
// hand-computed values.
module tb_epl_frame_detect;
    localparam int L = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fast_eth = 1'b1;
    logic         rm_crs_dv = 1'b0;
    logic [1:0]   rm_rx_data = 2'b00;
    logic         soc_det, hdr_vld, is_epl, frame_done, frame_err;
    logic [6:0]   msg_type;
    logic [7:0]   dst_node, src_node;
    logic [L-1:0] frame_len;

    epl_frame_detect #(.L(L), .ETHERTYPE(16'h88AB), .SLOW_DIV(10)) dut (
        .clk(clk), .rst(rst), .fast_eth(fast_eth),
        .rm_crs_dv(rm_crs_dv), .rm_rx_data(rm_rx_data),
        .soc_det(soc_det), .hdr_vld(hdr_vld), .is_epl(is_epl),
        .msg_type(msg_type), .dst_node(dst_node), .src_node(src_node),
        .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor
    int           soc_cnt = 0, soc_cyc = 0, hdr_cnt = 0, done_cnt = 0, coinc = 0;
    logic [6:0]   h_msg = '0;
    logic [7:0]   h_dst = '0, h_src = '0;
    logic [L-1:0] d_len = '0;
    logic         d_err = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (soc_det) begin soc_cnt++; soc_cyc = cyc; end
            if (hdr_vld) begin hdr_cnt++; h_msg = msg_type; h_dst = dst_node; h_src = src_node; end
            if (frame_done) begin done_cnt++; d_len = frame_len; d_err = frame_err; end
            if (soc_det && frame_done) coinc++;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [7:0] fb [0:2199];
    int drv_cyc = 0, soc_drv = 0;
    int s_soc, s_hdr, s_done;

    task automatic dib(input logic crs, input logic [1:0] d);
        @(negedge clk);
        rm_crs_dv  = crs;
        rm_rx_data = d;
        drv_cyc    = cyc;
        repeat ((fast_eth ? 1 : 10) - 1) @(negedge clk);
    endtask

    task automatic byte_tx(input logic [7:0] b, input int idx);
        for (int k = 0; k < 4; k++) begin
            dib(1'b1, b[2*k +: 2]);
            if (idx == 14 && k == 3) soc_drv = drv_cyc;
        end
    endtask

    task automatic send_frame(input int n, input int extra, input bit idle);
        logic [7:0] tb_b;
        for (int i = 0; i < 7; i++) byte_tx(8'h55, -1);
        byte_tx(8'hD5, -1);
        for (int i = 0; i < n; i++) byte_tx(fb[i], i);
        tb_b = fb[n];
        for (int k = 0; k < extra; k++) dib(1'b1, tb_b[2*k +: 2]);
        if (idle) repeat (4) dib(1'b0, 2'b00);
    endtask

    task automatic build(input logic [15:0] et, input logic [7:0] b14, b15, b16, input int n);
        for (int i = 0; i < n + 1; i++) fb[i] = 8'(i * 7 + 3);
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        fb[14] = b14;
        fb[15] = b15;
        fb[16] = b16;
    endtask

    task automatic snap();
        s_soc = soc_cnt; s_hdr = hdr_cnt; s_done = done_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_soc", 32'(soc_det), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_len", 32'(frame_len), 32'd0);
        chk("rst_msg", 32'(msg_type), 32'd0);
        rst = 1'b0;
        repeat (2) dib(1'b0, 2'b00);

        // SoC at 100 Mbit
        build(16'h88AB, 8'h01, 8'hFF, 8'hF0, 60);
        snap();
        send_frame(60, 0, 1'b1);
        chk("soc1_cnt", 32'(soc_cnt - s_soc), 32'd1);
        chk("soc1_lat", 32'(soc_cyc - soc_drv), 32'd1);
        chk("soc1_hdr", 32'(hdr_cnt - s_hdr), 32'd1);
        chk("soc1_msg", 32'(h_msg), 32'h01);
        chk("soc1_dst", 32'(h_dst), 32'hFF);
        chk("soc1_src", 32'(h_src), 32'hF0);
        chk("soc1_done", 32'(done_cnt - s_done), 32'd1);
        chk("soc1_len", 32'(d_len), 32'd60);
        chk("soc1_err", 32'(d_err), 32'd0);
        chk("soc1_epl", 32'(is_epl), 32'd1);

        // PReq with reserved bit set
        build(16'h88AB, 8'h83, 8'h01, 8'hF0, 60);
        snap();
        send_frame(60, 0, 1'b1);
        chk("preq_soc", 32'(soc_cnt - s_soc), 32'd0);
        chk("preq_hdr", 32'(hdr_cnt - s_hdr), 32'd1);
        chk("preq_msg", 32'(h_msg), 32'h03);
        chk("preq_dst", 32'(h_dst), 32'h01);
        chk("preq_msgo", 32'(msg_type), 32'h03);

        // SoC at 10 Mbit
        fast_eth = 1'b0;
        build(16'h88AB, 8'h01, 8'hFF, 8'hF0, 60);
        snap();
        send_frame(60, 0, 1'b1);
        chk("slow_cnt", 32'(soc_cnt - s_soc), 32'd1);
        chk("slow_lat", 32'(soc_cyc - soc_drv), 32'd6);
        chk("slow_hdr", 32'(hdr_cnt - s_hdr), 32'd1);
        chk("slow_msg", 32'(h_msg), 32'h01);
        chk("slow_dst", 32'(h_dst), 32'hFF);
        chk("slow_src", 32'(h_src), 32'hF0);
        chk("slow_len", 32'(d_len), 32'd60);
        chk("slow_err", 32'(d_err), 32'd0);
        fast_eth = 1'b1;
        repeat (2) dib(1'b0, 2'b00);

        // IPv4 frame with 0x01 at byte 14
        build(16'h0800, 8'h01, 8'hFF, 8'hF0, 60);
        snap();
        send_frame(60, 0, 1'b1);
        chk("ip_epl", 32'(is_epl), 32'd0);
        chk("ip_soc", 32'(soc_cnt - s_soc), 32'd0);
        chk("ip_hdr", 32'(hdr_cnt - s_hdr), 32'd0);
        chk("ip_done", 32'(done_cnt - s_done), 32'd1);
        chk("ip_msg", 32'(msg_type), 32'h01);
        chk("ip_src", 32'(src_node), 32'hF0);

        // runt with a partial byte
        build(16'h88AB, 8'h01, 8'hFF, 8'hF0, 20);
        snap();
        send_frame(10, 2, 1'b1);
        chk("runt_done", 32'(done_cnt - s_done), 32'd1);
        chk("runt_len", 32'(d_len), 32'd10);
        chk("runt_err", 32'(d_err), 32'd1);

        // oversize frame saturates the length
        build(16'h88AB, 8'h03, 8'h01, 8'hF0, 2100);
        snap();
        send_frame(2100, 0, 1'b1);
        chk("long_len", 32'(d_len), 32'd2047);
        chk("long_err", 32'(d_err), 32'd0);
        chk("long_soc", 32'(soc_cnt - s_soc), 32'd0);

        // reset in the middle of a frame
        build(16'h88AB, 8'h01, 8'hFF, 8'hF0, 60);
        snap();
        send_frame(8, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        rm_crs_dv = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_len", 32'(frame_len), 32'd0);
        chk("mrst_msg", 32'(msg_type), 32'd0);
        chk("mrst_flags", 32'({soc_det, hdr_vld, is_epl, frame_done, frame_err}), 32'd0);
        chk("mrst_nodes", 32'({dst_node, src_node}), 32'd0);
        rst = 1'b0;
        repeat (4) dib(1'b0, 2'b00);
        chk("mrst_nodone", 32'(done_cnt - s_done), 32'd0);

        snap();
        send_frame(60, 0, 1'b1);
        chk("post_soc", 32'(soc_cnt - s_soc), 32'd1);
        chk("post_lat", 32'(soc_cyc - soc_drv), 32'd1);
        chk("post_hdr", 32'(hdr_cnt - s_hdr), 32'd1);
        chk("post_len", 32'(d_len), 32'd60);
        chk("coincide", 32'(coinc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
